// File: rtl/timer_ctrl_if.sv
// timer_ctrl_if: control/config/status bundle between a host (master) and timer_ctrl (slave)
// Signals: cfg_valid/cfg_ready handshake with cfg_period, cfg_prescale, cfg_oneshot;
//          start/stop run control; count, busy, tick status; irq/overrun with irq_ack.
interface timer_ctrl_if #(
    parameter int WIDTH   = 4,
    parameter int PRESC_W = 4
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [WIDTH-1:0]   cfg_period;
    logic [PRESC_W-1:0] cfg_prescale;
    logic               cfg_oneshot;
    logic               start;
    logic               stop;
    logic [WIDTH-1:0]   count;
    logic               busy;
    logic               tick;
    logic               irq;
    logic               irq_ack;
    logic               overrun;

    modport master (
        output cfg_valid, cfg_period, cfg_prescale, cfg_oneshot, start, stop, irq_ack,
        input  cfg_ready, count, busy, tick, irq, overrun
    );

    modport slave (
        input  cfg_valid, cfg_period, cfg_prescale, cfg_oneshot, start, stop, irq_ack,
        output cfg_ready, count, busy, tick, irq, overrun
    );
endinterface

// File: rtl/timer_ctrl.sv
// timer_ctrl: programmable prescaled timer with one-shot/periodic modes and sticky irq/overrun
// Ports: clk, reset (sync, active-high); bus (timer_ctrl_if.slave) carries the config
//        handshake, start/stop control, count/busy/tick status and irq/overrun/irq_ack.
module timer_ctrl #(
    parameter int WIDTH   = 4,
    parameter int PRESC_W = 4
) (
    input  logic         clk,
    input  logic         reset,
    timer_ctrl_if.slave  bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_count;
    logic [PRESC_W-1:0] r_presc;
    logic [WIDTH-1:0]   r_period;
    logic [PRESC_W-1:0] r_prescale;
    logic               r_oneshot;
    logic               r_tick;
    logic               r_irq;
    logic               r_ovr;

    logic w_step;
    logic w_fire;

    assign w_step = r_presc == r_prescale;
    // A terminal step only fires when neither stop nor a restart overrides it.
    assign w_fire = r_state == RUN && !bus.stop && !bus.start && w_step && r_count == r_period;

    assign bus.cfg_ready = r_state == IDLE && !reset;
    assign bus.count     = r_count;
    assign bus.busy      = r_state == RUN;
    assign bus.tick      = r_tick;
    assign bus.irq       = r_irq;
    assign bus.overrun   = r_ovr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_presc    <= '0;
            r_period   <= '1;
            r_prescale <= '0;
            r_oneshot  <= 1'b0;
            r_tick     <= 1'b0;
            r_irq      <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            r_tick <= w_fire;
            r_irq  <= w_fire | (r_irq & ~bus.irq_ack);
            r_ovr  <= ~bus.irq_ack & (r_ovr | (w_fire & r_irq));
            if (bus.cfg_valid && bus.cfg_ready) begin
                r_period   <= bus.cfg_period;
                r_prescale <= bus.cfg_prescale;
                r_oneshot  <= bus.cfg_oneshot;
            end
            if (r_state == IDLE) begin
                if (bus.start && !bus.stop) begin
                    r_state <= RUN;
                    r_count <= '0;
                    r_presc <= '0;
                end
            end else if (bus.stop) begin
                r_state <= IDLE;
            end else if (bus.start) begin
                r_count <= '0;
                r_presc <= '0;
            end else if (w_step) begin
                r_presc <= '0;
                if (r_count == r_period) begin
                    r_count <= '0;
                    if (r_oneshot)
                        r_state <= IDLE;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: scoreboard bench for timer_ctrl with an elapsed-time reference model
module tb_timer_ctrl;
    typedef logic [8:0] obs_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    timer_ctrl_if #(.WIDTH(4), .PRESC_W(4)) bus();
    timer_ctrl #(.WIDTH(4), .PRESC_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    obs_t q[$];
    int checks = 0;
    int failures = 0;

    // Model: a run is described by cycles elapsed since start; count and tick follow by division.
    bit m_run = 0, m_tick = 0, m_irq = 0, m_ovr = 0, m_os = 0;
    int m_el = 0, m_frz = 0, m_p = 15, m_ps = 0;

    function automatic obs_t m_obs();
        int c;
        c = m_run ? m_el / (m_ps + 1) : m_frz;
        return {c[3:0], m_run, m_tick, m_irq, m_ovr, !m_run && !reset};
    endfunction

    task automatic cyc();
        bit f;
        int len;
        q.push_back(m_obs());
        f = 0;
        if (reset) begin
            m_run = 0; m_el = 0; m_frz = 0; m_p = 15; m_ps = 0; m_os = 0;
            m_irq = 0; m_ovr = 0;
        end else begin
            if (bus.cfg_valid && !m_run) begin
                m_p = int'(bus.cfg_period); m_ps = int'(bus.cfg_prescale); m_os = bus.cfg_oneshot;
            end
            len = (m_p + 1) * (m_ps + 1);
            if (!m_run) begin
                if (bus.start && !bus.stop) begin m_run = 1; m_el = 0; end
            end else if (bus.stop) begin
                m_frz = m_el / (m_ps + 1); m_run = 0;
            end else if (bus.start) begin
                m_el = 0;
            end else begin
                m_el++;
                if (m_el == len) begin
                    f = 1; m_el = 0;
                    if (m_os) begin m_run = 0; m_frz = 0; end
                end
            end
            m_ovr = !bus.irq_ack && (m_ovr || (f && m_irq));
            m_irq = f || (m_irq && !bus.irq_ack);
        end
        m_tick = f;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        obs_t e, a;
        if (q.size() > 0) begin
            e = q.pop_front();
            a = {bus.count, bus.busy, bus.tick, bus.irq, bus.overrun, bus.cfg_ready};
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL obs t=%0t: got cnt=%0d busy=%b tick=%b irq=%b ovr=%b rdy=%b, want cnt=%0d busy=%b tick=%b irq=%b ovr=%b rdy=%b",
                         $time, a[8:5], a[4], a[3], a[2], a[1], a[0], e[8:5], e[4], e[3], e[2], e[1], e[0]);
            end
        end
    end

    task automatic run_n(input int n);
        repeat (n) cyc();
    endtask

    task automatic pulse_start();
        bus.start = 1; cyc(); bus.start = 0;
    endtask

    task automatic pulse_stop();
        bus.stop = 1; cyc(); bus.stop = 0;
    endtask

    task automatic pulse_ack();
        bus.irq_ack = 1; cyc(); bus.irq_ack = 0;
    endtask

    task automatic cfg(input int p, input int ps, input bit os);
        bus.cfg_valid = 1; bus.cfg_period = 4'(p); bus.cfg_prescale = 4'(ps); bus.cfg_oneshot = os;
        cyc();
        bus.cfg_valid = 0;
    endtask

    initial begin
        bus.cfg_valid = 0; bus.cfg_period = '0; bus.cfg_prescale = '0; bus.cfg_oneshot = 0;
        bus.start = 0; bus.stop = 0; bus.irq_ack = 0;
        @(posedge clk); #1;
        cyc();
        reset = 0;
        // default config wraps like a 0..15 counter
        cyc();
        pulse_start(); run_n(20); pulse_stop();
        // periodic prescaled
        cfg(3, 2, 0); pulse_start(); run_n(40); pulse_stop();
        // one-shot
        pulse_ack();
        cfg(5, 0, 1); pulse_start(); run_n(25);
        // stop at 7, restart at 9, stop+start together
        cfg(15, 0, 0); pulse_start(); run_n(7); pulse_stop(); run_n(3);
        pulse_start(); run_n(9); pulse_start(); run_n(3);
        bus.stop = 1; bus.start = 1; cyc(); bus.stop = 0; bus.start = 0; run_n(2);
        // irq and overrun, then ack coincident with ticks
        pulse_ack(); cfg(1, 0, 0); pulse_start(); run_n(6); pulse_ack(); run_n(1);
        bus.irq_ack = 1; run_n(4); bus.irq_ack = 0; run_n(3); pulse_stop();
        // period 0 ticks every cycle
        cfg(0, 0, 0); pulse_start(); run_n(5); pulse_stop();
        // config held off during RUN, reset mid-run
        cfg(15, 0, 0); pulse_start(); run_n(3);
        bus.cfg_valid = 1; bus.cfg_period = 4'd2; bus.cfg_prescale = 4'd0; bus.cfg_oneshot = 0;
        run_n(10); pulse_stop(); cyc(); bus.cfg_valid = 0;
        pulse_start(); run_n(8);
        cfg(15, 0, 0); pulse_start(); run_n(10);
        reset = 1; cyc(); reset = 0;
        pulse_start(); run_n(18);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom % 200) == 0;
            bus.cfg_valid = ($urandom % 8) == 0;
            bus.cfg_period = 4'($urandom % 16);
            bus.cfg_prescale = 4'($urandom % 4);
            bus.cfg_oneshot = 1'($urandom % 2);
            bus.start = ($urandom % 20) == 0;
            bus.stop = ($urandom % 25) == 0;
            bus.irq_ack = ($urandom % 6) == 0;
            cyc();
        end
        reset = 0; bus.cfg_valid = 0; bus.start = 0; bus.stop = 0; bus.irq_ack = 0;
        cyc();
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
